// File: rtl/fetch_mem_arb_pkg.sv
// rtl/fetch_mem_arb_pkg.sv - shared state encodings and default parameters for fetch_mem_arb
package fetch_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        DM_BUSY = 2'b10
    } arb_state_t;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_MAX_DATA_BURST = 4;
    localparam int DEF_TIMEOUT        = 64;

endpackage

// File: rtl/fetch_mem_arb_watchdog.sv
// rtl/fetch_mem_arb_watchdog.sv - busy-cycle watchdog for fetch_mem_arb (used with ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   busy       arbiter currently owns the memory
//   mem_done   memory completes the current access this cycle
//   expire     this busy cycle is the TIMEOUT-th one without mem_done; abort now
//   err        sticky error, cleared only by rst
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic mem_done,
    output logic expire,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt counts the stalled busy cycles already seen, so the cycle in which
    // cnt == TIMEOUT-1 is the TIMEOUT-th one.
    assign expire = busy & ~mem_done & (cnt == CW'(TIMEOUT - 1));

    // IDLE always precedes a BUSY state, so holding cnt at zero while idle
    // clears it on every BUSY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (!busy || expire)
                cnt <= '0;
            else if (!mem_done)
                cnt <= cnt + CW'(1);
            if (expire)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_mem_arb.sv
// rtl/fetch_mem_arb.sv - fetch/data arbiter for one shared variable-latency memory
//
// Optional feature: define ARB_TIMEOUT_EN to enable the busy watchdog (arb_watchdog)
// that aborts an access after TIMEOUT stalled cycles and sets the sticky err.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   if_req/if_addr                    fetch request (held until if_done) and PC
//   if_done/if_instr/if_stall         fetch completion pulse, instruction, stall
//   dm_req/dm_wr/dm_addr/dm_wdata     data request (held until dm_done)
//   dm_done/dm_rdata/dm_stall         data completion pulse, read data, stall
//   mem_en/mem_wr/mem_addr/mem_wdata  shared memory command, stable while busy
//   mem_rdata/mem_done                memory read data and completion
//   err                               sticky watchdog error (0 without ARB_TIMEOUT_EN)
module fetch_mem_arb
    import fetch_mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    localparam int BW = $clog2(MAX_DATA_BURST + 1);

    arb_state_t        state;
    logic [BW-1:0]     burst_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_instr_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic busy;
    logic burst_full;
    logic grant_dm;
    logic grant_if;
    logic expire;

    assign busy       = (state != IDLE);
    assign burst_full = (burst_cnt == BW'(MAX_DATA_BURST));

    // Data has priority unless fetch has already waited through a full burst.
    assign grant_dm = dm_req & ~(if_req & burst_full);
    assign grant_if = if_req & ~grant_dm;

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .mem_done (mem_done),
        .expire   (expire),
        .err      (err)
    );
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            if_instr_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state   <= DM_BUSY;
                        addr_q  <= dm_addr;
                        wr_q    <= dm_wr;
                        wdata_q <= dm_wdata;
                    end else if (grant_if) begin
                        state   <= IF_BUSY;
                        addr_q  <= if_addr;
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                    // Only data grants made while fetch is waiting count
                    // toward the burst limit.
                    if (!if_req || grant_if)
                        burst_cnt <= '0;
                    else if (grant_dm && !burst_full)
                        burst_cnt <= burst_cnt + BW'(1);
                end
                IF_BUSY: begin
                    if (mem_done) begin
                        if_instr_q <= mem_rdata;
                        state      <= IDLE;
                    end else if (expire) begin
                        state <= IDLE;
                    end
                end
                DM_BUSY: begin
                    if (mem_done) begin
                        if (!wr_q)
                            dm_rdata_q <= mem_rdata;
                        state <= IDLE;
                    end else if (expire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is combinational on mem_done so the pipeline sees the
    // result in the same cycle the memory delivers it.
    assign if_done  = (state == IF_BUSY) & mem_done;
    assign dm_done  = (state == DM_BUSY) & mem_done;
    assign if_instr = if_done ? mem_rdata : if_instr_q;
    assign dm_rdata = (dm_done & ~wr_q) ? mem_rdata : dm_rdata_q;

    // Stalls are masked during reset so every output reads 0 while rst is high.
    assign if_stall = if_req & ~if_done & ~rst;
    assign dm_stall = dm_req & ~dm_done & ~rst;

    // Command decoded from the state register: drops with the async reset.
    assign mem_en    = busy;
    assign mem_wr    = (state == DM_BUSY) & wr_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = (state == DM_BUSY) ? wdata_q : '0;

endmodule

// File: tb/tb_fetch_mem_arb.sv
// tb/tb_fetch_mem_arb.sv - self-checking bench for fetch_mem_arb
module tb_fetch_mem_arb;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXB = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO  = 8;
`else
    localparam int TMO  = 64;
`endif

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_instr;
    logic          if_stall;
    logic          dm_req;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          err;

    fetch_mem_arb #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MAX_DATA_BURST (MAXB),
        .TIMEOUT        (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_instr  (if_instr),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: consecutive data grants given while fetch waited,
    // last results returned to each requester, expected err.
    int            streak;
    logic [DW-1:0] exp_if_instr;
    logic [DW-1:0] exp_dm_rdata;
    logic          exp_err;

    typedef struct {
        bit          ir;
        logic [15:0] ia;
        bit          dr;
        bit          dw;
        logic [15:0] da;
        logic [15:0] dd;
        int          lat;
        logic [15:0] rd;
        bit          drop;
        int          owner;   // 0 = fetch, 1 = data
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pick(input bit ir, input bit dr);
        return (dr && !(ir && streak >= MAXB)) ? 1 : 0;
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // IDLE cycle that follows the access.
    task automatic run_access(input bit ir, input logic [15:0] ia, input bit dr, input bit dw,
                              input logic [15:0] da, input logic [15:0] dd, input int lat,
                              input logic [15:0] rd, input bit drop, input int owner,
                              input string tag);
        bit own_req;
        if_req = ir; if_addr = ia; dm_req = dr; dm_wr = dw; dm_addr = da; dm_wdata = dd;
        mem_done = 1'b0;
        #3;
        chk({tag, ".idle_en"}, mem_en, 0);
        chk({tag, ".idle_if_stall"}, if_stall, ir);
        chk({tag, ".idle_if_instr"}, if_instr, exp_if_instr);
        chk({tag, ".idle_dm_rdata"}, dm_rdata, exp_dm_rdata);
        @(posedge clk); #1;
        own_req = 1'b1;
        if (drop) begin
            if_req = 1'b0; dm_req = 1'b0; own_req = 1'b0;
        end
        for (int k = 1; k <= lat; k++) begin
            mem_done  = (k == lat);
            mem_rdata = (k == lat) ? rd : 16'($urandom);
            #3;
            chk({tag, ".mem_en"}, mem_en, 1);
            chk({tag, ".mem_addr"}, mem_addr, owner ? da : ia);
            chk({tag, ".mem_wr"}, mem_wr, owner ? dw : 1'b0);
            if (owner == 1) chk({tag, ".mem_wdata"}, mem_wdata, dd);
            chk({tag, ".err"}, err, exp_err);
            if (k == lat) begin
                chk({tag, ".if_done"}, if_done, owner == 0);
                chk({tag, ".dm_done"}, dm_done, owner == 1);
                if (owner == 0) exp_if_instr = rd;
                if (owner == 1 && !dw) exp_dm_rdata = rd;
            end else begin
                chk({tag, ".if_done_early"}, if_done, 0);
                chk({tag, ".dm_done_early"}, dm_done, 0);
                if (owner == 0) chk({tag, ".if_stall"}, if_stall, own_req);
                else            chk({tag, ".dm_stall"}, dm_stall, own_req);
            end
            chk({tag, ".if_instr"}, if_instr, exp_if_instr);
            chk({tag, ".dm_rdata"}, dm_rdata, exp_dm_rdata);
            @(posedge clk); #1;
        end
        mem_done = 1'b0;
        if (owner == 0 || !ir) streak = 0;
        else if (streak < MAXB) streak++;
    endtask

    task automatic idle_cycle();
        if_req = 1'b0; dm_req = 1'b0; mem_done = 1'b0;
        #3;
        chk("idle.mem_en", mem_en, 0);
        @(posedge clk); #1;
        streak = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int          seq[15];
        int          exp_pat[6];
        int          owner;
        bit          ip, dp, dw_r;
        logic [15:0] ia_r, da_r, dd_r;

        tbl[0] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 3, 16'hA5A5, 0, 0};
        tbl[1] = '{0, 16'h0000, 1, 1, 16'h0100, 16'h1234, 2, 16'hDEAD, 0, 1};
        tbl[2] = '{0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 1, 16'hBEEF, 0, 1};
        tbl[3] = '{1, 16'h0020, 1, 0, 16'h0300, 16'h0000, 1, 16'h5A5A, 0, 1};
        tbl[4] = '{1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 2, 16'h0F0F, 0, 0};
        tbl[5] = '{1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2, 16'h1357, 1, 0};
        exp_pat = '{1, 1, 1, 1, 0, 1};

        streak = 0; exp_if_instr = '0; exp_dm_rdata = '0; exp_err = 1'b0;
        rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_wr = 0; dm_addr = 0;
        dm_wdata = 0; mem_rdata = 16'hFFFF; mem_done = 1'b1;

        // Reset state: even with mem_done high, everything reads 0.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outs", {mem_en, mem_wr, if_done, dm_done, if_stall, dm_stall, err},  0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.if_instr", if_instr, 0);
        chk("rst.dm_rdata", dm_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // mem_done while idle is ignored.
        mem_done = 1'b1;
        #3;
        chk("idle_done.if_done", if_done, 0);
        chk("idle_done.dm_done", dm_done, 0);
        chk("idle_done.if_instr", if_instr, 0);
        @(posedge clk); #1;
        idle_cycle();

        // Table-driven single accesses, including a fetch dropped mid-access.
        for (int i = 0; i < 6; i++)
            run_access(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd,
                       tbl[i].lat, tbl[i].rd, tbl[i].drop, tbl[i].owner,
                       $sformatf("tbl%0d", i));
        // Next grant after the dropped fetch must still see an IDLE bubble.
        run_access(0, 16'h0, 1, 0, 16'h0400, 16'h0, 1, 16'h2468, 0, 1, "after_drop");
        idle_cycle();

        // Continuous contention: 4 data grants then 1 fetch.
        for (int n = 0; n < 15; n++) begin
            owner  = pick(1, 1);
            seq[n] = owner;
            run_access(1, 16'h1000 + 16'(n), 1, 0, 16'h2000 + 16'(n), 16'h0, 1,
                       16'($urandom), 0, owner, "cont");
        end
        for (int n = 0; n < 6; n++)
            chk($sformatf("cont.order%0d", n), seq[n], exp_pat[n]);
        idle_cycle();

        // Randomized traffic: losers keep their request pending.
        ip = 0; dp = 0; ia_r = 0; da_r = 0; dd_r = 0; dw_r = 0;
        for (int n = 0; n < 60; n++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia_r = 16'($urandom); end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; da_r = 16'($urandom); dd_r = 16'($urandom); dw_r = 1'($urandom_range(0, 1));
            end
            if (!ip && !dp) begin dp = 1; da_r = 16'($urandom); dd_r = 16'($urandom); dw_r = 0; end
            owner = pick(ip, dp);
            run_access(ip, ia_r, dp, dw_r, da_r, dd_r, $urandom_range(1, 4), 16'($urandom),
                       0, owner, "rand");
            if (owner == 1) dp = 0; else ip = 0;
        end
        idle_cycle();

        // Asynchronous reset in DM_BUSY.
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0777; dm_wdata = 16'h0;
        @(posedge clk); #1;
        #3;
        chk("arst.busy", mem_en, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst.mem_en", mem_en, 0);
        chk("arst.outs", {mem_wr, if_done, dm_done, if_stall, dm_stall, err}, 0);
        chk("arst.mem_addr", mem_addr, 0);
        chk("arst.if_instr", if_instr, 0);
        chk("arst.dm_rdata", dm_rdata, 0);
        mem_done = 1'b1;
        #1;
        chk("arst.no_done", dm_done, 0);
        @(posedge clk); #1;
        rst = 1'b0; dm_req = 0; mem_done = 0;
        exp_if_instr = '0; exp_dm_rdata = '0; streak = 0;
        idle_cycle();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: fetch never completes, aborts after TMO busy cycles.
        if_req = 1; if_addr = 16'h0AAA;
        @(posedge clk); #1;
        for (int k = 1; k <= TMO; k++) begin
            if (k == TMO) if_req = 0;
            #3;
            chk("tmo.busy", mem_en, 1);
            chk("tmo.err_low", err, 0);
            chk("tmo.no_done", if_done, 0);
            @(posedge clk); #1;
        end
        #3;
        chk("tmo.err", err, 1);
        chk("tmo.idle", mem_en, 0);
        exp_err = 1'b1;
        @(posedge clk); #1;
        streak = 0;
        run_access(1, 16'h0BBB, 0, 0, 16'h0, 16'h0, 2, 16'hC0DE, 0, 0, "tmo_after");
        idle_cycle();
        chk("tmo.sticky", err, 1);
`else
        // Without the watchdog the arbiter waits indefinitely.
        if_req = 1; if_addr = 16'h0AAA;
        repeat (30) @(posedge clk);
        #1;
        chk("nowd.still_busy", mem_en, 1);
        chk("nowd.err", err, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if_req = 0;
        exp_if_instr = '0; exp_dm_rdata = '0; streak = 0;
        idle_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
